// File: rtl/mmio_break_sched.sv
// mmio_break_sched: round-robin scheduler for the host-serviced MMIO break path.
// One requester is granted at a time. The block raises a break to the host,
// waits for the host resume (turn2run) and for any pending irq to clear.
// It then releases the requester and rotates priority.
// Ports:
//   clk, reset    : clock, async active-high reset
//   mmio_req      : per-requester pending MMIO write (level)
//   irq2          : external interrupt pending
//   irq2_full     : interrupt queue full
//   turn2run      : host resume pulse
//   grant, svc_id : one-hot / binary requester being serviced
//   irq_mmio      : break request to host
//   break_encore  : irq2 | irq2_full | irq_mmio
//   stall         : per-requester hold while a round is active
//   timeout_err   : sticky, break not serviced in time
//   debug_state   : current FSM state
module mmio_break_sched #(
  parameter int N_REQ      = 2,
  parameter int TMO_W      = 16,
  parameter int RESUME_DLY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           mmio_req,
  input  logic                       irq2,
  input  logic                       irq2_full,
  input  logic                       turn2run,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   svc_id,
  output logic                       irq_mmio,
  output logic                       break_encore,
  output logic [N_REQ-1:0]           stall,
  output logic                       timeout_err,
  output logic [2:0]                 debug_state
);

  localparam int IW = $clog2(N_REQ);
  localparam int DW = $clog2(RESUME_DLY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_BREAK  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESUME = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [N_REQ-1:0]  r_grant;
  logic [IW-1:0]     r_svc;
  logic [IW-1:0]     r_rr;
  logic              r_irq;
  logic              r_terr;
  logic [TMO_W-1:0]  r_cnt;
  logic [DW-1:0]     r_dly;

  logic [IW-1:0]     w_pick;
  logic              w_pick_vld;
  logic              w_load;
  logic              w_release;
  logic              w_set_err;
  logic              w_cnt_sat;
  logic              w_dly_done;
  logic [IW-1:0]     w_rr_nxt;
  int                w_idx;

  // The counter hits all-ones on the edge that ends this cycle.
  assign w_cnt_sat  = (r_cnt == {{(TMO_W-1){1'b1}}, 1'b0});
  assign w_dly_done = (r_dly == DW'(RESUME_DLY - 1));
  assign w_rr_nxt   = (r_svc == IW'(N_REQ - 1)) ? '0 : r_svc + IW'(1);

  // Round-robin pick: scanning downward lets the lowest offset win.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr) + k) % N_REQ;
      if (mmio_req[w_idx]) begin
        w_pick     = IW'(w_idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_load    = 1'b0;
    w_release = 1'b0;
    w_set_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|mmio_req) w_nxt = S_ARB;
      end
      S_ARB: begin
        if (w_pick_vld) begin
          w_nxt  = S_BREAK;
          w_load = 1'b1;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      S_BREAK: begin
        if (turn2run) begin
          w_nxt = irq2 ? S_WAIT : S_RESUME;
        end else if (w_cnt_sat) begin
          w_nxt     = S_ERR;
          w_set_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (!irq2) w_nxt = S_RESUME;
      end
      S_RESUME: begin
        if (w_dly_done) begin
          w_nxt     = S_IDLE;
          w_release = 1'b1;
        end
      end
      S_ERR: begin
        if (turn2run) w_nxt = S_RESUME;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_svc   <= '0;
      r_rr    <= '0;
      r_irq   <= 1'b0;
      r_terr  <= 1'b0;
      r_cnt   <= '0;
      r_dly   <= '0;
    end else begin
      if (w_load) begin
        r_grant <= N_REQ'(1) << w_pick;
        r_svc   <= w_pick;
      end else if (w_release) begin
        r_grant <= '0;
        r_svc   <= '0;
        r_rr    <= w_rr_nxt;
      end
      r_irq  <= (w_nxt == S_BREAK) || (w_nxt == S_WAIT) ||
                (w_nxt == S_ERR);
      r_terr <= r_terr | w_set_err;
      // Counters restart whenever their state is left.
      r_cnt  <= (r_state == S_BREAK) ? r_cnt + TMO_W'(1) : '0;
      r_dly  <= (r_state == S_RESUME) ? r_dly + DW'(1) : '0;
    end
  end

  assign grant        = r_grant;
  assign svc_id       = r_svc;
  assign irq_mmio     = r_irq;
  assign timeout_err  = r_terr;
  assign break_encore = irq2 | irq2_full | r_irq;
  assign stall        = mmio_req & {N_REQ{r_state != S_IDLE}};
  assign debug_state  = r_state;

endmodule

// File: tb/tb_mmio_break_sched.sv
// tb_mmio_break_sched: directed table of per-cycle vectors plus
// hand-written timeout, tie and async-reset sequences.
module tb_mmio_break_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mmio_req;
  logic       irq2, irq2_full, turn2run;
  logic [1:0] grant;
  logic [0:0] svc_id;
  logic       irq_mmio, break_encore, timeout_err;
  logic [1:0] stall;
  logic [2:0] debug_state;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_break_sched #(.N_REQ(2), .TMO_W(4), .RESUME_DLY(2)) dut (
    .clk(clk), .reset(reset), .mmio_req(mmio_req), .irq2(irq2),
    .irq2_full(irq2_full), .turn2run(turn2run), .grant(grant),
    .svc_id(svc_id), .irq_mmio(irq_mmio), .break_encore(break_encore),
    .stall(stall), .timeout_err(timeout_err), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       i2, full, t2r;
    logic [2:0] st;
    logic [1:0] gnt;
    logic       irq, enc;
    logic [1:0] stl;
    logic       terr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] req, input logic i2, input logic f,
                     input logic t, input logic [2:0] st,
                     input logic [1:0] g, input logic irq, input logic enc,
                     input logic [1:0] stl, input logic terr);
    vec_t v;
    v.req = req; v.i2 = i2; v.full = f; v.t2r = t; v.st = st;
    v.gnt = g; v.irq = irq; v.enc = enc; v.stl = stl; v.terr = terr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".state"}, 32'(debug_state), 0);
    chk({nm, ".grant"}, 32'(grant), 0);
    chk({nm, ".svc"}, 32'(svc_id), 0);
    chk({nm, ".irq"}, 32'(irq_mmio), 0);
    chk({nm, ".enc"}, 32'(break_encore), 0);
    chk({nm, ".stall"}, 32'(stall), 0);
    chk({nm, ".terr"}, 32'(timeout_err), 0);
  endtask

  initial begin
    reset = 1'b1; mmio_req = '0; irq2 = 0; irq2_full = 0; turn2run = 0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // fairness: 3 rounds with both requesting, rr starts at 0
    for (int r = 0; r < 3; r++) begin
      logic [1:0] g;
      g = (r == 1) ? 2'b10 : 2'b01;
      add(2'b11, 0, 0, 0, 3'd1, 2'b00, 0, 0, 2'b11, 0);
      add(2'b11, 0, 0, 0, 3'd2, g,     1, 1, 2'b11, 0);
      add(2'b11, 0, 0, 1, 3'd4, g,     0, 0, 2'b11, 0);
      add(2'b11, 0, 0, 0, 3'd4, g,     0, 0, 2'b11, 0);
      add((r == 2) ? 2'b00 : 2'b11, 0, 0, 0, 3'd0, 2'b00, 0, 0, 2'b00, 0);
    end
    // irq inputs never start a round
    add(2'b00, 1, 0, 1, 3'd0, 2'b00, 0, 1, 2'b00, 0);
    add(2'b00, 0, 1, 0, 3'd0, 2'b00, 0, 1, 2'b00, 0);
    // single request, rr=1 wraps to requester 0, resume 10 cycles later
    add(2'b01, 0, 0, 0, 3'd1, 2'b00, 0, 0, 2'b01, 0);
    add(2'b01, 0, 0, 0, 3'd2, 2'b01, 1, 1, 2'b01, 0);
    for (int k = 0; k < 9; k++)
      add(2'b01, 0, 0, 0, 3'd2, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 0, 0, 1, 3'd4, 2'b01, 0, 0, 2'b01, 0);
    add(2'b01, 0, 0, 0, 3'd4, 2'b01, 0, 0, 2'b01, 0);
    add(2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0, 2'b00, 0);
    // irq pending at resume: 5 cycles in WAIT_IRQ, turn2run ignored there
    add(2'b01, 0, 0, 0, 3'd1, 2'b00, 0, 0, 2'b01, 0);
    add(2'b01, 0, 0, 0, 3'd2, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 1, 0, 1, 3'd3, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 1, 0, 0, 3'd3, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 1, 0, 1, 3'd3, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 1, 0, 0, 3'd3, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 1, 0, 0, 3'd3, 2'b01, 1, 1, 2'b01, 0);
    add(2'b01, 0, 0, 0, 3'd4, 2'b01, 0, 0, 2'b01, 0);
    add(2'b01, 0, 0, 0, 3'd4, 2'b01, 0, 0, 2'b01, 0);
    add(2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0, 2'b00, 0);
    // request vanishes during ARB: back to IDLE, no grant
    add(2'b10, 0, 0, 0, 3'd1, 2'b00, 0, 0, 2'b10, 0);
    add(2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0, 2'b00, 0);
    // request dropped after grant: round continues
    add(2'b10, 0, 0, 0, 3'd1, 2'b00, 0, 0, 2'b10, 0);
    add(2'b10, 0, 0, 0, 3'd2, 2'b10, 1, 1, 2'b10, 0);
    add(2'b00, 0, 0, 0, 3'd2, 2'b10, 1, 1, 2'b00, 0);
    add(2'b00, 0, 0, 1, 3'd4, 2'b10, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 3'd4, 2'b10, 0, 0, 2'b00, 0);
    add(2'b00, 0, 0, 0, 3'd0, 2'b00, 0, 0, 2'b00, 0);

    foreach (tbl[i]) begin
      string s;
      s = $sformatf("v%0d", i);
      mmio_req = tbl[i].req; irq2 = tbl[i].i2;
      irq2_full = tbl[i].full; turn2run = tbl[i].t2r;
      tick();
      chk({s, ".state"}, 32'(debug_state), 32'(tbl[i].st));
      chk({s, ".grant"}, 32'(grant), 32'(tbl[i].gnt));
      chk({s, ".irq"}, 32'(irq_mmio), 32'(tbl[i].irq));
      chk({s, ".enc"}, 32'(break_encore), 32'(tbl[i].enc));
      chk({s, ".stall"}, 32'(stall), 32'(tbl[i].stl));
      chk({s, ".terr"}, 32'(timeout_err), 32'(tbl[i].terr));
      if (tbl[i].gnt != 2'b00)
        chk({s, ".svc"}, 32'(svc_id), (tbl[i].gnt == 2'b10) ? 1 : 0);
    end
    irq2 = 0; irq2_full = 0; turn2run = 0;

    // timeout: 15 BREAK cycles then ERR, sticky error
    mmio_req = 2'b01;
    tick(); chk("tmo.arb", 32'(debug_state), 1);
    tick(); chk("tmo.brk", 32'(debug_state), 2);
    chk("tmo.gnt", 32'(grant), 1);
    repeat (14) tick();
    chk("tmo.pre", 32'(debug_state), 2);
    chk("tmo.pre_err", 32'(timeout_err), 0);
    tick();
    chk("tmo.err", 32'(debug_state), 5);
    chk("tmo.terr", 32'(timeout_err), 1);
    chk("tmo.irq", 32'(irq_mmio), 1);
    repeat (3) tick();
    chk("tmo.hold", 32'(debug_state), 5);
    turn2run = 1; tick(); turn2run = 0;
    chk("tmo.res", 32'(debug_state), 4);
    chk("tmo.res_irq", 32'(irq_mmio), 0);
    mmio_req = 2'b00;
    tick(); tick();
    chk("tmo.idle", 32'(debug_state), 0);
    chk("tmo.sticky", 32'(timeout_err), 1);
    chk("tmo.gnt0", 32'(grant), 0);

    // tie: turn2run on the saturating cycle wins
    reset = 1; #2; reset = 0;
    chk("tie.rst_terr", 32'(timeout_err), 0);
    mmio_req = 2'b01;
    tick(); tick();
    repeat (14) tick();
    chk("tie.pre", 32'(debug_state), 2);
    turn2run = 1; tick(); turn2run = 0;
    chk("tie.res", 32'(debug_state), 4);
    chk("tie.terr", 32'(timeout_err), 0);
    mmio_req = 2'b00;
    tick(); tick();
    chk("tie.idle", 32'(debug_state), 0);

    // async reset mid-BREAK, then rr pointer back at 0
    mmio_req = 2'b01;
    tick(); tick();
    chk("arst.brk", 32'(debug_state), 2);
    chk("arst.gnt_pre", 32'(grant), 1);
    #3 reset = 1;
    #1;
    chk("arst.st", 32'(debug_state), 0);
    chk("arst.gnt", 32'(grant), 0);
    chk("arst.irq", 32'(irq_mmio), 0);
    chk("arst.enc", 32'(break_encore), 0);
    chk("arst.stall", 32'(stall), 0);
    mmio_req = 2'b10;
    #2 reset = 0;
    tick(); chk("arst.arb", 32'(debug_state), 1);
    tick();
    chk("arst.gnt2", 32'(grant), 2);
    chk("arst.svc", 32'(svc_id), 1);
    chk("arst.irq2", 32'(irq_mmio), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
